// File: rtl/reg_file_dumper.sv
// -----------------------------------------------------------------------------
// reg_file_dumper
//
// Purpose:
//   Read-side master that walks the processor register file through its two
//   combinational read ports, two registers per fetch. Each (index, value)
//   pair is streamed out over a valid/ready interface to a trace/debug sink.
//   The register file write port is never touched.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous, active-high reset
//   start_i      begin a dump (sampled only while idle)
//   abort_i      synchronous cancel, highest priority after reset
//   rd1_addr_o   read port 1 address (even register of the pair)
//   rd2_addr_o   read port 2 address (odd register of the pair)
//   rd1_data_i   read port 1 data (combinational from the register file)
//   rd2_data_i   read port 2 data (combinational from the register file)
//   out_valid_o  stream word valid
//   out_ready_i  sink ready
//   out_data_o   register value
//   out_index_o  register number of out_data_o
//   busy_o       high whenever a dump is in progress
//   done_o       one-cycle pulse when a dump completes
// -----------------------------------------------------------------------------
module reg_file_dumper #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter int SKIP_ZERO  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] rd1_addr_o,
    output logic [ADDR_WIDTH-1:0] rd2_addr_o,
    input  logic [DATA_WIDTH-1:0] rd1_data_i,
    input  logic [DATA_WIDTH-1:0] rd2_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH-1:0] out_index_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SEND0  = 3'd2,
        S_SEND1  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // Pair counter k runs 0 .. NUM_REGS/2-1.
    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(NUM_REGS / 2 - 1);

    state_t                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   k_q,         k_d;
    logic [DATA_WIDTH-1:0]   buf0_q,      buf0_d;
    logic [DATA_WIDTH-1:0]   buf1_q,      buf1_d;
    logic [ADDR_WIDTH-1:0]   rd1_addr_q,  rd1_addr_d;
    logic [ADDR_WIDTH-1:0]   rd2_addr_q,  rd2_addr_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic [ADDR_WIDTH-1:0]   out_index_q, out_index_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    // 2k and 2k+1 in ADDR_WIDTH bits; the parameter constraint keeps them
    // in range, so the dropped MSB of k is always zero.
    function automatic logic [ADDR_WIDTH-1:0] even_idx(input logic [ADDR_WIDTH-1:0] k);
        return k << 1;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] odd_idx(input logic [ADDR_WIDTH-1:0] k);
        return (k << 1) | ADDR_WIDTH'(1);
    endfunction

    // -------------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            rd1_addr_q  <= '0;
            rd2_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            rd1_addr_q  <= rd1_addr_d;
            rd2_addr_q  <= rd2_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        rd1_addr_d  = rd1_addr_q;
        rd2_addr_d  = rd2_addr_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    k_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Snapshot taken here; later register writes are not seen.
                buf0_d = rd1_data_i;
                buf1_d = rd2_data_i;
                if ((SKIP_ZERO != 0) && (k_q == '0)) begin
                    state_d = S_SEND1;
                end else begin
                    state_d = S_SEND0;
                end
            end
            S_SEND0: begin
                // out_valid_q is always high here, so ready alone completes
                // the handshake.
                if (out_ready_i) begin
                    state_d = S_SEND1;
                end
            end
            S_SEND1: begin
                if (out_ready_i) begin
                    if (k_q == LAST_K) begin
                        state_d = S_FINISH;
                    end else begin
                        k_d     = k_q + ADDR_WIDTH'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous handshake
        // (that word is still considered delivered by the sink).
        if (abort_i) begin
            state_d = S_IDLE;
            k_d     = '0;
        end

        // Outputs are decoded from the next state so they are valid in the
        // very cycle the state is entered.
        if (state_d == S_FETCH) begin
            rd1_addr_d = even_idx(k_d);
            rd2_addr_d = odd_idx(k_d);
        end
        if (state_d == S_SEND0) begin
            out_data_d  = buf0_d;
            out_index_d = even_idx(k_d);
        end
        if (state_d == S_SEND1) begin
            out_data_d  = buf1_d;
            out_index_d = odd_idx(k_d);
        end
        out_valid_d = (state_d == S_SEND0) || (state_d == S_SEND1);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FINISH);
    end

    assign rd1_addr_o  = rd1_addr_q;
    assign rd2_addr_o  = rd2_addr_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_index_o = out_index_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_reg_file_dumper.sv
// -----------------------------------------------------------------------------
// tb_reg_file_dumper
//
// Bench for reg_file_dumper. Two instances share one register file model:
// dut_a dumps every register, dut_b skips emitting register 0. Expected
// streams are built from a snapshot of the register file taken before START.
// -----------------------------------------------------------------------------
module tb_reg_file_dumper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] regs [32];

    // dut_a signals
    logic        start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
    logic [4:0]  a_rd1_addr, a_rd2_addr, a_index;
    logic [31:0] a_rd1_data, a_rd2_data, a_data;
    logic        a_valid, a_busy, a_done;

    // dut_b signals
    logic        start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
    logic [4:0]  b_rd1_addr, b_rd2_addr, b_index;
    logic [31:0] b_rd1_data, b_rd2_data, b_data;
    logic        b_valid, b_busy, b_done;

    assign a_rd1_data = regs[a_rd1_addr];
    assign a_rd2_data = regs[a_rd2_addr];
    assign b_rd1_data = regs[b_rd1_addr];
    assign b_rd2_data = regs[b_rd2_addr];

    reg_file_dumper #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32), .SKIP_ZERO(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .abort_i(abort_a),
        .rd1_addr_o(a_rd1_addr), .rd2_addr_o(a_rd2_addr),
        .rd1_data_i(a_rd1_data), .rd2_data_i(a_rd2_data),
        .out_valid_o(a_valid), .out_ready_i(ready_a),
        .out_data_o(a_data), .out_index_o(a_index),
        .busy_o(a_busy), .done_o(a_done)
    );

    reg_file_dumper #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32), .SKIP_ZERO(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .abort_i(abort_b),
        .rd1_addr_o(b_rd1_addr), .rd2_addr_o(b_rd2_addr),
        .rd1_data_i(b_rd1_data), .rd2_data_i(b_rd2_data),
        .out_valid_o(b_valid), .out_ready_i(ready_b),
        .out_data_o(b_data), .out_index_o(b_index),
        .busy_o(b_busy), .done_o(b_done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic set_ready(input bit sel, input logic v);
        if (sel) ready_b = v; else ready_a = v;
    endtask

    // One complete dump on the selected instance, checked word by word.
    // exp_done = 0 means the completion cycle is not fixed (random ready).
    task automatic run_dump(input bit sel, input bit rnd, input int exp_done, input bit poke5);
        logic [31:0] exp_d[$];
        int          exp_i[$];
        int          first;
        bit          stall, seen_done, rdy;
        logic [31:0] pd, d;
        logic [4:0]  pi, ix;
        logic        v, bz, dn;
        int          got;
        first = sel ? 1 : 0;
        stall = 0; seen_done = 0; got = 0; pd = '0; pi = '0;
        for (int i = first; i < 32; i++) begin
            exp_i.push_back(i);
            exp_d.push_back(regs[i]);
        end
        set_ready(sel, 1'b1);
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        for (int c = 1; c <= 600 && !seen_done; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            v  = sel ? b_valid : a_valid;
            d  = sel ? b_data  : a_data;
            ix = sel ? b_index : a_index;
            bz = sel ? b_busy  : a_busy;
            dn = sel ? b_done  : a_done;
            if (stall) begin
                chk("stall_valid", 64'(v), 64'(1));
                chk("stall_data",  64'(d), 64'(pd));
                chk("stall_index", 64'(ix), 64'(pi));
            end
            chk("busy_during_dump", 64'(bz), 64'(1));
            if (dn) begin
                seen_done = 1;
                chk("words_at_done", 64'(got), 64'(exp_i.size()));
                chk("valid_at_done", 64'(v), 64'(0));
                if (exp_done != 0) chk("done_cycle", 64'(c), 64'(exp_done));
            end
            // A START while busy must be ignored.
            if (c == 5) set_start(sel, 1'b1);
            if (c == 6) set_start(sel, 1'b0);
            // Write x5 after pair k=2 has been captured.
            if (poke5 && v && ix == 5'd4) regs[5] = 32'hDEAD_BEEF;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            set_ready(sel, rdy);
            if (v && rdy) begin
                if (got < exp_i.size()) begin
                    chk("word_index", 64'(ix), 64'(exp_i[got]));
                    chk("word_data",  64'(d),  64'(exp_d[got]));
                end else begin
                    chk("extra_word", 64'(1), 64'(0));
                end
                $display("dut%s word %0d: index=%0d data=%08h", sel ? "_b" : "_a", got, ix, d);
                got++;
            end
            stall = v && !rdy;
            pd = d;
            pi = ix;
        end
        if (!seen_done) begin
            chk("done_timeout", 64'(0), 64'(1));
        end else begin
            @(posedge clk); #1;
            chk("done_single_pulse", 64'(sel ? b_done : a_done), 64'(0));
            chk("idle_after_done",   64'(sel ? b_busy : a_busy), 64'(0));
        end
        set_ready(sel, 1'b0);
    endtask

    // Start dut_a with ready high and stop once index idx is presented.
    task automatic run_to(input logic [4:0] idx);
        bit ok;
        ok = 0;
        ready_a = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            if (a_valid && a_index == idx) ok = 1;
            else begin @(posedge clk); #1; end
        end
        chk("reach_index", 64'(ok), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);

        // Reset state
        #2;
        chk("rst_valid", 64'(a_valid), 64'(0));
        chk("rst_data",  64'(a_data),  64'(0));
        chk("rst_index", 64'(a_index), 64'(0));
        chk("rst_addr1", 64'(a_rd1_addr), 64'(0));
        chk("rst_addr2", 64'(a_rd2_addr), 64'(0));
        chk("rst_busy",  64'(a_busy), 64'(0));
        chk("rst_done",  64'(a_done), 64'(0));
        chk("rst_busy_b", 64'(b_busy), 64'(0));
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Full dump, ready high, with a write to x5 after capture
        run_dump(1'b0, 1'b0, 49, 1'b1);
        regs[5] = 32'hA000_0005;

        // SKIP_ZERO instance
        run_dump(1'b1, 1'b0, 48, 1'b0);

        // Random back-pressure
        run_dump(1'b0, 1'b1, 0, 1'b0);

        // Abort while index 9 is stalled
        run_to(5'd9);
        ready_a = 1'b0;
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        chk("abort_valid", 64'(a_valid), 64'(0));
        chk("abort_busy",  64'(a_busy),  64'(0));
        chk("abort_done",  64'(a_done),  64'(0));
        @(posedge clk); #1;
        chk("abort_no_done_later", 64'(a_done), 64'(0));
        chk("abort_stays_idle",    64'(a_busy), 64'(0));
        $display("abort at index 9: valid=%0d busy=%0d done=%0d", a_valid, a_busy, a_done);

        // START together with ABORT in idle stays idle
        start_a = 1'b1;
        abort_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("start_abort_idle", 64'(a_busy), 64'(0));
        @(posedge clk); #1;
        chk("start_abort_idle2", 64'(a_busy), 64'(0));

        // Restart after abort begins at index 0
        run_dump(1'b0, 1'b0, 49, 1'b0);

        // Asynchronous reset in the middle of SEND1
        run_to(5'd7);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(a_valid), 64'(0));
        chk("arst_data",  64'(a_data),  64'(0));
        chk("arst_index", 64'(a_index), 64'(0));
        chk("arst_busy",  64'(a_busy),  64'(0));
        chk("arst_done",  64'(a_done),  64'(0));
        chk("arst_addr1", 64'(a_rd1_addr), 64'(0));
        $display("async reset mid-send1: valid=%0d data=%08h index=%0d", a_valid, a_data, a_index);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("after_rst_idle", 64'(a_busy), 64'(0));
        run_dump(1'b0, 1'b0, 49, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
